// File: rtl/imm_gen_if.sv
// Valid/ready bus for the immediate generator stage: instruction in, operand out.
interface imm_gen_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic            in_lt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_lt, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_lt, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator behind a 2-entry skid buffer.
// in_ready is a flop so execute backpressure never reaches decode combinationally.
module imm_gen_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  imm_gen_if.slave   bus
);
  localparam logic [2:0] FMT_NONE = 3'd0, FMT_R = 3'd1, FMT_I = 3'd2, FMT_S = 3'd3,
                         FMT_B = 3'd4, FMT_U = 3'd5, FMT_J = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state;
  entry_t          main_q, skid_q, dec;
  logic            valid_q, ready_q;
  logic [ILEN-1:0] instr;
  logic [31:0]     v32;
  logic [63:0]     wide;

  assign instr = bus.in_instr;

  // Every format fits in 32 bits with bit 31 already correct, so one final
  // replication of v32[31] gives the XLEN-wide result.
  always_comb begin
    v32         = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (instr[6:0])
      7'b0110011: begin
        v32     = {31'b0, bus.in_lt};
        dec.fmt = FMT_R;
      end
      7'b0010011: begin
        dec.fmt = FMT_I;
        if (instr[13:12] == 2'b01)
          v32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        else
          v32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0000011, 7'b1100111: begin
        v32     = {{20{instr[31]}}, instr[31:20]};
        dec.fmt = FMT_I;
      end
      7'b0100011: begin
        v32     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.fmt = FMT_S;
      end
      7'b1100011: begin
        v32     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        v32     = {instr[31:12], 12'b0};
        dec.fmt = FMT_U;
      end
      7'b1101111: begin
        v32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec.fmt = FMT_J;
      end
      default: dec.illegal = 1'b1;
    endcase
    wide    = {{32{v32[31]}}, v32};
    dec.imm = wide[XLEN-1:0];
  end

  logic accept, pop;
  assign accept = bus.in_valid & ready_q;
  assign pop    = valid_q & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            main_q  <= dec;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q  <= dec;
            ready_q <= 1'b0;
            state   <= TWO;
          end else if (pop) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=64 and XLEN=32 instances driven in lockstep,
// checked against a queue-based reference model and a table of known encodings.
module tb_imm_gen_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(64)) b64();
  imm_gen_if #(.XLEN(32)) b32();

  assign b32.in_valid  = b64.in_valid;
  assign b32.in_instr  = b64.in_instr;
  assign b32.in_lt     = b64.in_lt;
  assign b32.out_ready = b64.out_ready;

  imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(b64));
  imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));

  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        lt;
    logic [63:0] i64;
    logic [31:0] i32;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic exp_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: immediates computed as signed integers from the field layout.
  function automatic exp_t ref_model(input logic [31:0] w, input logic lt);
    exp_t   r;
    longint v;
    logic   shift;
    v = 0; shift = 1'b0;
    r.fmt = 3'd0; r.ill = 1'b0;
    case (w[6:0])
      7'h33: begin v = longint'(lt); r.fmt = 3'd1; end
      7'h13: begin
        r.fmt = 3'd2;
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
          shift = 1'b1; v = longint'(w[25:20]);
        end else v = longint'($signed(w[31:20]));
      end
      7'h03, 7'h67: begin v = longint'($signed(w[31:20])); r.fmt = 3'd2; end
      7'h23: begin v = longint'($signed({w[31:25], w[11:7]})); r.fmt = 3'd3; end
      7'h63: begin v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); r.fmt = 3'd4; end
      7'h37, 7'h17: begin v = longint'($signed(w[31:12])) * 4096; r.fmt = 3'd5; end
      7'h6F: begin v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); r.fmt = 3'd6; end
      default: r.ill = 1'b1;
    endcase
    r.i64 = v;
    r.i32 = shift ? {27'b0, w[24:20]} : v[31:0];
    return r;
  endfunction

  task automatic compare();
    chk("out_valid64", b64.out_valid, q.size() > 0);
    chk("out_valid32", b32.out_valid, q.size() > 0);
    chk("in_ready", b64.in_ready, exp_ready);
    if (q.size() > 0) begin
      chk("imm64", b64.out_imm, q[0].i64);
      chk("imm32", b32.out_imm, q[0].i32);
      chk("fmt", b64.out_fmt, q[0].fmt);
      chk("illegal", b64.out_illegal, q[0].ill);
    end
  endtask

  // Called at a negedge; drives one cycle and checks outputs at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic lt,
                       input logic ordy, input logic fl);
    logic acc, pop;
    b64.in_valid = v; b64.in_instr = w; b64.in_lt = lt; b64.out_ready = ordy; flush = fl;
    acc = v && exp_ready;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ref_model(w, lt));
    end
    exp_ready = q.size() < 2;
    @(negedge clk);
    compare();
  endtask

  vec_t vecs[$];
  logic [6:0] ops[12];

  initial begin
    vecs = '{
      '{32'hFFF00093, 1'b0, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd2, 1'b0},
      '{32'hFE000EE3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd4, 1'b0},
      '{32'h800000B7, 1'b0, 64'hFFFFFFFF80000000, 32'h80000000, 3'd5, 1'b0},
      '{32'h03F09093, 1'b0, 64'd63,               32'd31,       3'd2, 1'b0},
      '{32'h00000033, 1'b1, 64'd1,                32'd1,        3'd1, 1'b0},
      '{32'h00000033, 1'b0, 64'd0,                32'd0,        3'd1, 1'b0},
      '{32'h0000007F, 1'b1, 64'd0,                32'd0,        3'd0, 1'b1},
      '{32'hFE112E23, 1'b0, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0},
      '{32'hFF9FF06F, 1'b0, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, 3'd6, 1'b0},
      '{32'h12345097, 1'b0, 64'h0000000012345000, 32'h12345000, 3'd5, 1'b0},
      '{32'h7FF13083, 1'b0, 64'h00000000000007FF, 32'h000007FF, 3'd2, 1'b0},
      '{32'h4200D093, 1'b0, 64'd32,               32'd0,        3'd2, 1'b0}
    };
    ops = '{7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h7F};

    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_lt = 1'b0; b64.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", b64.out_valid, 0);
    chk("rst_ready", b64.in_ready, 0);
    chk("rst_imm", b64.out_imm, 0);
    chk("rst_fmt", b64.out_fmt, 0);
    chk("rst_illegal", b64.out_illegal, 0);
    reset = 1'b0;
    cycle(0, 0, 0, 1, 0);
    chk("ready_after_rst", b64.in_ready, 1);

    foreach (vecs[i]) begin
      cycle(1, vecs[i].instr, vecs[i].lt, 1, 0);
      chk($sformatf("vec%0d_valid", i), b64.out_valid, 1);
      chk($sformatf("vec%0d_imm64", i), b64.out_imm, vecs[i].i64);
      chk($sformatf("vec%0d_imm32", i), b32.out_imm, vecs[i].i32);
      chk($sformatf("vec%0d_fmt", i), b64.out_fmt, vecs[i].fmt);
      chk($sformatf("vec%0d_ill", i), b64.out_illegal, vecs[i].ill);
    end
    cycle(0, 0, 0, 1, 0);

    // Backpressure: three back-to-back with out_ready low, then drain.
    cycle(1, 32'h00100093, 0, 0, 0);
    cycle(1, 32'h00200093, 0, 0, 0);
    chk("bp_full_ready", b64.in_ready, 0);
    cycle(1, 32'h00300093, 0, 0, 0);
    chk("bp_hold_imm", b64.out_imm, 1);
    cycle(1, 32'h00300093, 0, 1, 0);
    chk("bp_second", b64.out_imm, 2);
    cycle(1, 32'h00300093, 0, 1, 0);
    chk("bp_third", b64.out_imm, 3);
    cycle(0, 0, 0, 1, 0);
    chk("bp_drained", b64.out_valid, 0);

    // Flush from TWO with a pending instruction.
    cycle(1, 32'h00100093, 0, 0, 0);
    cycle(1, 32'h00200093, 0, 0, 0);
    cycle(1, 32'h00700093, 0, 0, 1);
    chk("flush_valid", b64.out_valid, 0);
    chk("flush_ready", b64.in_ready, 1);
    cycle(0, 0, 0, 1, 0);
    chk("flush_gone", b64.out_valid, 0);

    // Reset mid-stream with one entry held.
    cycle(1, 32'h00500093, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid64", b64.out_valid, 0);
    chk("midrst_valid32", b32.out_valid, 0);
    chk("midrst_ready", b64.in_ready, 0);
    q.delete();
    exp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, 0, 1, 0);
    chk("midrst_ready_back", b64.in_ready, 1);
    cycle(1, 32'h00900093, 0, 1, 0);
    chk("midrst_latency", b64.out_valid, 1);
    chk("midrst_imm", b64.out_imm, 9);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      cycle($urandom_range(0, 3) != 0, w, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate generator for the RISC-V datapath.
- Sits between instruction decode and the ALU/address operand mux.
- Decodes every RV base immediate format (I, S, B, U, J, shift-amount) plus the R-type set-less-than result into an XLEN-wide operand.
- Places the result behind a valid/ready pipeline stage with a 2-entry skid buffer, so backpressure from execute never drops or reorders instructions.

Parameters:
- XLEN, 64, operand width; legal values are 32 and 64.
- ILEN, 32, instruction width; fixed at 32, present for port sizing.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; empties the stage.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  ILEN  raw instruction word.
- in_lt  input  1  comparator less-than flag for R-type slt/sltu.
- out_valid  output  1  out_* holds a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- out_imm  output  XLEN  extended immediate / slt result.
- out_fmt  output  3  0 NONE, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
- out_illegal  output  1  opcode not recognised.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While reset is high, out_valid=0, in_ready=0, out_imm=0, out_fmt=0 and out_illegal=0. in_ready rises on the first clock edge after reset deasserts.
- Decode is combinational on in_instr[6:0]:
  - 0110011 (R): imm = {XLEN-1 zeros, in_lt}; fmt R.
  - 0010011 with funct3 001/101 (shifts): zero-extended shamt; in[25:20] when XLEN=64, in[24:20] when XLEN=32; fmt I.
  - 0010011 (other funct3), 0000011 (loads), 1100111 (jalr): sext(in[31:20]); fmt I.
  - 0100011 (stores): sext({in[31:25], in[11:7]}); fmt S.
  - 1100011 (branches): sext({in[31], in[7], in[30:25], in[11:8], 1'b0}); fmt B.
  - 0110111 (lui), 0010111 (auipc): sext({in[31:12], 12'b0}); fmt U.
  - 1101111 (jal): sext({in[31], in[19:12], in[20], in[30:21], 1'b0}); fmt J.
  - Anything else: imm 0, fmt NONE, illegal=1.
- Sign extension always replicates in[31] up to XLEN-1. No partial or mixed-width assignments.
- Storage: a main output register plus one skid register. State machine over {EMPTY, ONE, TWO}:
  - EMPTY -> ONE on accept.
  - ONE -> ONE on accept and pop together; -> EMPTY on pop only; -> TWO on accept while out_ready=0.
  - TWO -> ONE on pop; the skid entry moves into the output register.
- Handshake:
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = (state != TWO); it is registered and has no combinational path from out_ready.
  - Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 per cycle when out_ready is held high.
  - Entries leave in acceptance order. in_lt is sampled with its instruction.
  - out_* stays stable while out_valid=1 and out_ready=0.
- Flush: goes to EMPTY next cycle and discards any same-cycle accept. Flush has priority over accept and pop. Data registers need not clear; out_valid=0 is sufficient.
- Reset mid-operation: all entries are lost immediately, with no output glitch beyond going invalid.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, fmt=2, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFFFFFFFFFC, fmt=4. Then lui x1,0x80000 (0x800000B7) -> 0xFFFFFFFF80000000, fmt=5. With XLEN=32, lui gives 0x80000000.
- slli x1,x1,63 (0x03F09093) -> out_imm=63, fmt=2. R-type add (0x00000033) with in_lt=1 -> out_imm=1, fmt=1. Opcode 0x7F -> imm 0, fmt 0, illegal=1.
- Backpressure: out_ready=0 while presenting 3 back-to-back instructions -> first two accepted, in_ready=0 on the third. Raise out_ready -> all three emerge in order, one per cycle, none lost or duplicated.
- Flush asserted with state TWO and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instruction never appears.
- Assert reset mid-stream with state ONE -> out_valid drops immediately, without a clock edge. After release, in_ready=1 within one cycle and a new instruction passes with 1-cycle latency.
